// File: rtl/cmos_gate_test_pkg.sv
// Shared types and constants for the CMOS gate test sequencer.
// Holds the FSM states, the Gray input walk and the reference truth tables.
package cmos_gate_test_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CHECK,
      ST_DONE
   } state_e;

   // Index 0 is the first vector driven; neighbouring entries differ in one bit.
   localparam logic [3:0][1:0] GRAY_SEQ = {2'b10, 2'b11, 2'b01, 2'b00};

   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_result_checker.sv
// Combinational compare of sampled gate outputs against their truth tables.
// Produces the mismatch vector, its popcount and the lowest mismatching index.
module gate_result_checker #(
   parameter int NUM_GATES = 4,
   parameter int GSEL_W    = 2,
   parameter int PC_W      = 3
) (
   input  logic [NUM_GATES-1:0]   dut_out,
   input  logic [NUM_GATES-1:0]   gate_en,
   input  logic [4*NUM_GATES-1:0] truth_tbl,
   input  logic [1:0]             vec,
   output logic [NUM_GATES-1:0]   mismatch,
   output logic [PC_W-1:0]        mism_cnt,
   output logic [GSEL_W-1:0]      low_idx
);

   for (genvar g = 0; g < NUM_GATES; g++) begin : g_cmp
      logic [3:0] nib;
      assign nib         = truth_tbl[4*g +: 4];
      assign mismatch[g] = gate_en[g] & (dut_out[g] ^ nib[vec]);
   end

   // Walk downwards so the last hit written is the lowest index.
   always_comb begin
      mism_cnt = '0;
      low_idx  = '0;
      for (int g = NUM_GATES - 1; g >= 0; g--) begin
         mism_cnt = mism_cnt + PC_W'(mismatch[g]);
         if (mismatch[g]) low_idx = GSEL_W'(g);
      end
   end

endmodule

// File: rtl/cmos_gate_test_seq.sv
// Walks all four input vectors across a bank of 2-input CMOS gates in Gray
// order, samples each gate after a settle time and accumulates results.
module cmos_gate_test_seq
   import cmos_gate_test_pkg::*;
#(
   parameter int NUM_GATES     = 4,
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 8,
   parameter int GSEL_W        = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [NUM_GATES-1:0]   gate_en,
   input  logic [4*NUM_GATES-1:0] truth_tbl,
   input  logic [NUM_GATES-1:0]   dut_out,
   output logic                   dut_a,
   output logic                   dut_b,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [NUM_GATES-1:0]   fail_mask,
   output logic [CNT_W-1:0]       err_count,
   output logic [GSEL_W-1:0]      first_fail_gate,
   output logic [1:0]             first_fail_vec
);

   localparam int SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int PC_W  = $clog2(NUM_GATES + 1);
   localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e                 state_q, state_d;
   logic [SC_W-1:0]        settle_cnt;
   logic [1:0]             vec_idx;
   logic [NUM_GATES-1:0]   en_q;
   logic [4*NUM_GATES-1:0] tt_q;
   logic [NUM_GATES-1:0]   mismatch;
   logic [PC_W-1:0]        mism_cnt;
   logic [GSEL_W-1:0]      low_idx;
   logic [SUM_W-1:0]       err_sum;
   logic                   settle_last;
   logic                   last_vec;

   gate_result_checker #(
      .NUM_GATES (NUM_GATES),
      .GSEL_W    (GSEL_W),
      .PC_W      (PC_W)
   ) u_chk (
      .dut_out   (dut_out),
      .gate_en   (en_q),
      .truth_tbl (tt_q),
      .vec       ({dut_a, dut_b}),
      .mismatch  (mismatch),
      .mism_cnt  (mism_cnt),
      .low_idx   (low_idx)
   );

   assign settle_last = (settle_cnt == SC_W'(SETTLE_CYCLES - 1));
   assign last_vec    = (vec_idx == 2'd3);
   assign err_sum     = SUM_W'(err_count) + SUM_W'(mism_cnt);

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_SETTLE;
         ST_SETTLE: if (settle_last) state_d = ST_CHECK;
         ST_CHECK:  state_d = last_vec ? ST_DONE : ST_SETTLE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         settle_cnt      <= '0;
         vec_idx         <= '0;
         en_q            <= '0;
         tt_q            <= '0;
         dut_a           <= 1'b0;
         dut_b           <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         fail_mask       <= '0;
         err_count       <= '0;
         first_fail_gate <= '0;
         first_fail_vec  <= '0;
      end else begin
         done <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  en_q            <= gate_en;
                  tt_q            <= truth_tbl;
                  fail_mask       <= '0;
                  err_count       <= '0;
                  first_fail_gate <= '0;
                  first_fail_vec  <= '0;
                  pass            <= 1'b0;
                  vec_idx         <= '0;
                  {dut_a, dut_b}  <= GRAY_SEQ[0];
                  settle_cnt      <= '0;
                  busy            <= 1'b1;
               end
            end
            ST_SETTLE: settle_cnt <= settle_cnt + SC_W'(1);
            ST_CHECK: begin
               fail_mask <= fail_mask | mismatch;
               err_count <= (err_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(err_sum);
               // Empty mask means no earlier check of this run has failed.
               if ((|mismatch) && (fail_mask == '0)) begin
                  first_fail_gate <= low_idx;
                  first_fail_vec  <= {dut_a, dut_b};
               end
               if (last_vec) begin
                  done <= 1'b1;
                  pass <= ((fail_mask | mismatch) == '0);
               end else begin
                  vec_idx        <= vec_idx + 2'd1;
                  {dut_a, dut_b} <= GRAY_SEQ[vec_idx + 2'd1];
                  settle_cnt     <= '0;
               end
            end
            ST_DONE: busy <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cmos_gate_test_seq.sv
// Directed bench: behavioural NAND/NOR/XOR/XNOR cells driven by the sequencer,
// a table of runs with hand-computed results, plus restart/reset corner cases.
module tb_cmos_gate_test_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  gate_en = '0;
   logic [15:0] truth_tbl = '0;
   logic [3:0]  dut_out;

   logic       dut_a, dut_b, busy, done, pass;
   logic [3:0] fail_mask;
   logic [7:0] err_count;
   logic [1:0] ffg, ffv;

   logic       a2, b2, busy2, done2, pass2;
   logic [3:0] mask2;
   logic [1:0] err2, ffg2, ffv2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // gate0 NAND, gate1 NOR, gate2 XOR, gate3 XNOR
   assign dut_out = {~(dut_a ^ dut_b), dut_a ^ dut_b, ~(dut_a | dut_b), ~(dut_a & dut_b)};

   cmos_gate_test_seq #(.NUM_GATES(4), .SETTLE_CYCLES(2), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .start(start), .gate_en(gate_en), .truth_tbl(truth_tbl),
      .dut_out(dut_out), .dut_a(dut_a), .dut_b(dut_b), .busy(busy), .done(done),
      .pass(pass), .fail_mask(fail_mask), .err_count(err_count),
      .first_fail_gate(ffg), .first_fail_vec(ffv)
   );

   cmos_gate_test_seq #(.NUM_GATES(4), .SETTLE_CYCLES(2), .CNT_W(2)) u_dut_sat (
      .clk(clk), .rst(rst), .start(start), .gate_en(gate_en), .truth_tbl(truth_tbl),
      .dut_out(dut_out), .dut_a(a2), .dut_b(b2), .busy(busy2), .done(done2),
      .pass(pass2), .fail_mask(mask2), .err_count(err2),
      .first_fail_gate(ffg2), .first_fail_vec(ffv2)
   );

   typedef struct {
      logic [15:0] tt;
      logic [3:0]  en;
      logic        pass;
      logic [3:0]  mask;
      logic [7:0]  err;
      logic [1:0]  err2;
      logic [1:0]  ffg;
      logic [1:0]  ffv;
   } run_t;

   run_t       tbl [6];
   logic [1:0] gray [4];

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   // Starts a run, follows it to done (bounded), pokes start during DONE,
   // and returns the cycle count at which done was seen.
   task automatic do_run(input logic [15:0] tt, input logic [3:0] en,
                         output int lat, output logic walk_ok, output logic done2_ok);
      @(negedge clk);
      truth_tbl = tt; gate_en = en; start = 1'b1;
      @(negedge clk);
      start = 1'b0; lat = 1; walk_ok = 1'b1;
      while (!done && lat < 40) begin
         if (lat <= 12 && ({dut_a, dut_b} !== gray[(lat-1)/3] || {a2, b2} !== gray[(lat-1)/3]
                           || busy !== 1'b1 || busy2 !== 1'b1))
            walk_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      done2_ok = done2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_run(input int i);
      int   lat;
      logic walk_ok, d2;
      do_run(tbl[i].tt, tbl[i].en, lat, walk_ok, d2);
      chk("done_latency", i, lat, 13);
      chk("vec_walk",     i, walk_ok, 1);
      chk("done_sat_dut", i, d2, 1);
      chk("busy_after",   i, {busy, busy2, done}, 3'b000);
      chk("pass",         i, pass, tbl[i].pass);
      chk("fail_mask",    i, fail_mask, tbl[i].mask);
      chk("err_count",    i, err_count, tbl[i].err);
      chk("err_sat",      i, err2, tbl[i].err2);
      chk("pass_sat",     i, pass2, tbl[i].pass);
      chk("ff_gate",      i, ffg, tbl[i].ffg);
      chk("ff_vec",       i, ffv, tbl[i].ffv);
   endtask

   initial begin
      logic done_seen;
      gray = '{2'b00, 2'b01, 2'b11, 2'b10};
      //            tt        en    pass  mask   err   err2  ffg   ffv
      tbl[0] = '{16'h9617, 4'hF, 1'b1, 4'h0, 8'd0, 2'd0, 2'd0, 2'b00};
      tbl[1] = '{16'h8617, 4'hF, 1'b0, 4'h8, 8'd1, 2'd1, 2'd3, 2'b00};
      tbl[2] = '{16'h0000, 4'hF, 1'b0, 4'hF, 8'd8, 2'd3, 2'd0, 2'b00};
      tbl[3] = '{16'h0000, 4'h0, 1'b1, 4'h0, 8'd0, 2'd0, 2'd0, 2'b00};
      tbl[4] = '{16'h0000, 4'h4, 1'b0, 4'h4, 8'd2, 2'd2, 2'd2, 2'b01};
      tbl[5] = '{16'h0000, 4'hA, 1'b0, 4'hA, 8'd3, 2'd3, 2'd1, 2'b00};

      repeat (3) @(negedge clk);
      chk("reset_vals", 0, {dut_a, dut_b, busy, done, pass, fail_mask, err_count, ffg, ffv}, '0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) check_run(i);

      // Second start at cycle 5 must be ignored; reset at cycle 7 aborts the run.
      @(negedge clk);
      truth_tbl = 16'h0000; gate_en = 4'hF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("restart_ignored", 0, {busy, dut_a, dut_b}, 3'b101);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrun_reset", 0, {dut_a, dut_b, busy, done, pass, fail_mask, err_count, ffg, ffv}, '0);
      rst = 1'b0;
      done_seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done || busy) done_seen = 1'b1;
      end
      chk("no_done_after_rst", 0, done_seen, 0);

      check_run(1);
      check_run(0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
